// File: rtl/mealy_frame_detector.sv
// mealy_frame_detector
//   Overlapping serial pattern detector wrapped in a fixed-length frame
//   controller. A frame starts on Start, runs for FRAME_LEN accepted bits
//   (Busy=1 and Enable=1), flags each pattern occurrence combinationally on
//   Match, counts occurrences with saturation, and pulses Done once the
//   frame completes. The final count is held until the next frame starts.
//
// Ports
//   Clock      in   1        rising-edge clock
//   Reset      in   1        synchronous, active-high reset
//   Start      in   1        begin a frame (ignored while Busy)
//   Enable     in   1        qualifies Din during a frame
//   Din        in   1        serial data bit, first pattern bit = PATTERN[3]
//   Busy       out  1        frame in progress (decoded straight from a flop)
//   Match      out  1        combinational: current accepted Din completes PATTERN
//   Done       out  1        one-cycle pulse after the last bit of a frame
//   MatchCount out COUNT_W   saturating match count for current/last frame

module mealy_frame_detector #(
  parameter logic [3:0] PATTERN   = 4'b1011,
  parameter int         FRAME_LEN = 16,
  parameter int         LEN_W     = 8,
  parameter int         COUNT_W   = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Enable,
  input  logic               Din,
  output logic               Busy,
  output logic               Match,
  output logic               Done,
  output logic [COUNT_W-1:0] MatchCount
);

  typedef enum logic [1:0] {S0, S1, S2, S3} det_state_t;
  typedef enum logic {IDLE, RUN} frame_state_t;

  // Next detector state for every (state, bit) pair, packed as 2-bit entries
  // indexed by {state, bit}. For a given prefix length k and new bit b the
  // received string is PATTERN's first k bits followed by b; the next state is
  // the longest suffix of that string (capped at 3) that is also a prefix of
  // PATTERN. The cap makes a full match fall back to its longest proper
  // border, which is what gives overlapping detection.
  function automatic logic [15:0] build_table();
    logic [15:0] tbl;
    logic [3:0]  s;
    logic        ok;
    int          best;
    tbl = '0;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 2; b++) begin
        s = '0;
        for (int j = 0; j < 4; j++) begin
          if (j < k) s[j] = PATTERN[3-j];
          else if (j == k) s[j] = b[0];
        end
        best = 0;
        for (int len = 1; len <= 3; len++) begin
          if (len <= k + 1) begin
            ok = 1'b1;
            for (int m = 0; m < 3; m++) begin
              if (m < len && s[k+1-len+m] != PATTERN[3-m]) ok = 1'b0;
            end
            if (ok) best = len;
          end
        end
        tbl[(k*2+b)*2 +: 2] = best[1:0];
      end
    end
    return tbl;
  endfunction

  localparam logic [15:0]        NEXT_TABLE = build_table();
  localparam logic [LEN_W-1:0]   LAST_BIT   = LEN_W'(FRAME_LEN - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

  frame_state_t       frame_state, frame_next;
  det_state_t         det_state, det_next;
  logic [LEN_W-1:0]   bit_cnt, cnt_next;
  logic [COUNT_W-1:0] count_next;
  logic               done_next;

  assign Busy = (frame_state == RUN);

  // State register: reset wins over everything, including a same-edge Start.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      frame_state <= IDLE;
      det_state   <= S0;
      bit_cnt     <= '0;
      MatchCount  <= '0;
      Done        <= 1'b0;
    end else begin
      frame_state <= frame_next;
      det_state   <= det_next;
      bit_cnt     <= cnt_next;
      MatchCount  <= count_next;
      Done        <= done_next;
    end
  end

  // Next-state and Mealy output logic. Everything holds unless a frame is
  // starting or a bit is accepted; Done defaults low so it is a single pulse.
  always_comb begin
    frame_next = frame_state;
    det_next   = det_state;
    cnt_next   = bit_cnt;
    count_next = MatchCount;
    done_next  = 1'b0;
    Match      = 1'b0;
    case (frame_state)
      IDLE: begin
        if (Start) begin
          frame_next = RUN;
          det_next   = S0;
          cnt_next   = '0;
          count_next = '0;
        end
      end
      RUN: begin
        if (Enable) begin
          Match    = (det_state == S3) && (Din == PATTERN[0]);
          det_next = det_state_t'(NEXT_TABLE[{det_state, Din, 1'b0} +: 2]);
          cnt_next = bit_cnt + LEN_W'(1);
          if (Match && MatchCount != COUNT_MAX) begin
            count_next = MatchCount + COUNT_W'(1);
          end
          if (bit_cnt == LAST_BIT) begin
            frame_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: frame_next = IDLE;
    endcase
  end

endmodule
